// File: rtl/debouncer_multi.sv
// debouncer_multi: NUM_CH switch debouncers sharing one tick prescaler; 2-flop sync, 4-state FSM, registered db/rise/fall.
// Latency sw->db: 2 + (STABLE_TICKS-1)*2^TICK_BITS+1 .. 2 + STABLE_TICKS*2^TICK_BITS cycles; no backpressure (free-running).
module debouncer_multi #(
  parameter int NUM_CH       = 4,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] sw,
  output logic [NUM_CH-1:0] db,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              tick
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_TICKS);

  // Bit 1 of the encoding is the debounced level, so db falls straight out of the state.
  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HIGH    = 2'b11,
    ST_WAIT_LO = 2'b10
  } state_e;

  logic [NUM_CH-1:0]    sync_meta;
  logic [NUM_CH-1:0]    s;
  logic [TICK_BITS-1:0] q;

  state_e           state_q  [NUM_CH];
  state_e           state_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [CNT_W-1:0] cnt_base [NUM_CH];
  logic [CNT_W-1:0] cnt_inc  [NUM_CH];
  logic [NUM_CH-1:0] db_d;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      s         <= '0;
    end else begin
      sync_meta <= sw;
      s         <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      tick <= 1'b0;
    end else begin
      q    <= q + 1'b1;
      tick <= &q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state. A mismatch seen from a settled state starts counting from zero, and a
  // tick in that same cycle already counts, which is what bounds the worst-case latency.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = ST_LOW;
      cnt_d[i]    = '0;
      cnt_base[i] = (state_q[i] == ST_WAIT_HI || state_q[i] == ST_WAIT_LO) ? cnt_q[i] : '0;
      cnt_inc[i]  = cnt_base[i] + 1'b1;
      case (state_q[i])
        ST_LOW, ST_WAIT_HI: begin
          if (!s[i]) begin
            state_d[i] = ST_LOW;
          end else if (tick && cnt_inc[i] == CNT_DONE) begin
            state_d[i] = ST_HIGH;
          end else begin
            state_d[i] = ST_WAIT_HI;
            cnt_d[i]   = tick ? cnt_inc[i] : cnt_base[i];
          end
        end
        ST_HIGH, ST_WAIT_LO: begin
          if (s[i]) begin
            state_d[i] = ST_HIGH;
          end else if (tick && cnt_inc[i] == CNT_DONE) begin
            state_d[i] = ST_LOW;
          end else begin
            state_d[i] = ST_WAIT_LO;
            cnt_d[i]   = tick ? cnt_inc[i] : cnt_base[i];
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so pulses line up with db.
  always_comb begin
    db_d   = '0;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      db_d[i]   = state_d[i][1];
      rise_d[i] = !state_q[i][1] &&  state_d[i][1];
      fall_d[i] =  state_q[i][1] && !state_d[i][1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      db   <= db_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi with NUM_CH=2, TICK_BITS=2 (tick every 4 cycles), STABLE_TICKS=3.
// Expected pulses are queued with hand-computed cycle numbers; a negedge monitor pops and compares.
module tb_debouncer_multi;

  localparam int NUM_CH       = 2;
  localparam int TICK_BITS    = 2;
  localparam int STABLE_TICKS = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] db;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              tick;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] db;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t mon_e;
  int     cyc;
  int     n_cmp  = 0;
  int     n_fail = 0;

  debouncer_multi #(
    .NUM_CH       (NUM_CH),
    .TICK_BITS    (TICK_BITS),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (sw),
    .db      (db),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick)
  );

  initial forever #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [1:0] r, input logic [1:0] f, input logic [1:0] d);
    pulse_t e;
    e.cyc  = c;
    e.rise = r;
    e.fall = f;
    e.db   = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_db"},   int'(db),   0);
    check({name, "_rise"}, int'(rise), 0);
    check({name, "_fall"}, int'(fall), 0);
  endtask

  always @(negedge clk) begin
    check("tick", int'(tick), int'(reset_n && cyc > 0 && (cyc % 4) == 0));
    if (rise != '0 || fall != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse at cyc %0d: rise=%b fall=%b db=%b, required no pulse", cyc, rise, fall, db);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cyc",  cyc,        mon_e.cyc);
        check("pulse_rise", int'(rise), int'(mon_e.rise));
        check("pulse_fall", int'(fall), int'(mon_e.fall));
        check("pulse_db",   int'(db),   int'(mon_e.db));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sw      = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("in_reset");
    check("in_reset_tick", int'(tick), 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    sw      = 2'b00;
    #1;
    check_quiet("release_c0");
    wait_cyc(1);
    check_quiet("release_c1");

    // Clean press: s rises in cycle 22, ticks 24/28/32, rise in cycle 33.
    wait_cyc(20);
    sw = 2'b01;
    expect_pulse(33, 2'b01, 2'b00, 2'b01);
    wait_cyc(32);
    check("press_pre_db", int'(db), 0);
    wait_cyc(34);
    check("press_post_db", int'(db), 1);

    // Release with a glitch landing on tick cycle 52: the return wins and the count restarts.
    wait_cyc(40);
    sw = 2'b00;
    expect_pulse(65, 2'b00, 2'b01, 2'b00);
    wait_cyc(50);
    sw = 2'b01;
    wait_cyc(51);
    sw = 2'b00;
    wait_cyc(64);
    check("release_hold_db", int'(db), 1);

    // Bounce: 6 cycles high, 1 low, five times; never three ticks in a row.
    for (int k = 0; k < 5; k++) begin
      wait_cyc(70 + 7 * k);
      sw = 2'b01;
      wait_cyc(76 + 7 * k);
      sw = 2'b00;
    end
    wait_cyc(108);
    check("bounce_db", int'(db), 0);

    // Both channels together; s changes on tick cycle 112, which counts.
    wait_cyc(110);
    sw = 2'b11;
    expect_pulse(121, 2'b11, 2'b00, 2'b11);
    wait_cyc(130);
    sw = 2'b01;
    expect_pulse(141, 2'b00, 2'b10, 2'b01);
    wait_cyc(142);
    check("ch1_drop_db", int'(db), 1);

    // Reset after channel 1 has counted two ticks (152, 156).
    wait_cyc(150);
    sw = 2'b11;
    wait_cyc(158);
    check("pre_reset_db", int'(db), 1);
    reset_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    expect_pulse(13, 2'b11, 2'b00, 2'b11);
    wait_cyc(12);
    check("rewait_db", int'(db), 0);
    wait_cyc(20);
    check("rewait_done_db", int'(db), 3);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_pulse: required rise=%b fall=%b at cyc %0d, never observed", mon_e.rise, mon_e.fall, mon_e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised successor to the single-switch debouncer.
- Debounces NUM_CH independent switch/button inputs using one shared free-running tick prescaler.
- Synchronises each raw input, then produces per-channel debounced levels plus single-cycle rise and fall pulses.
- Sits between board pushbuttons/switches and the counter and display control logic, so downstream blocks no longer need their own edge detectors.

Parameters:
- NUM_CH, 4: number of independent input channels (>=1).
- TICK_BITS, 19: prescaler width; tick period = 2^TICK_BITS clk cycles (~10 ms at 50 MHz).
- STABLE_TICKS, 3: consecutive ticks an input must differ from the debounced level before that level flips (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw  input  NUM_CH  raw asynchronous switch inputs, bit i = channel i.
- db  output  NUM_CH  debounced level per channel.
- rise  output  NUM_CH  one-cycle pulse when db[i] goes 0->1.
- fall  output  NUM_CH  one-cycle pulse when db[i] goes 1->0.
- tick  output  1  prescaler tick, exposed for test and for sharing.

Behaviour:
Reset:
- reset_n low clears everything asynchronously: synchroniser flops, prescaler, all channel FSMs and counters, db, rise, fall and tick.
- Every output is 0 during reset and in the first cycle after release.

Synchroniser:
- Two flops per channel; s[i] is sw[i] delayed by 2 cycles.

Prescaler:
- TICK_BITS-bit free-running up counter q; wraps from all-ones to 0.
- tick is registered and high for exactly one cycle each time q wraps, i.e. once every 2^TICK_BITS cycles.
- First tick after reset release occurs at cycle 2^TICK_BITS.

Per-channel FSM, 4 states, each with a tick counter cnt of width clog2(STABLE_TICKS+1):
- LOW (db=0): s=1 -> WAIT_HI, cnt=0. Otherwise stay.
- WAIT_HI (db=0):
  - s=0 -> LOW, cnt=0.
  - Otherwise on tick: cnt+1. If cnt+1 == STABLE_TICKS -> HIGH, rise pulse.
- HIGH (db=1): s=0 -> WAIT_LO, cnt=0. Otherwise stay.
- WAIT_LO (db=1):
  - s=1 -> HIGH, cnt=0.
  - Otherwise on tick: cnt+1. If cnt+1 == STABLE_TICKS -> LOW, fall pulse.
- Unused encodings -> LOW.

Outputs and timing:
- db, rise and fall are registered.
- rise/fall assert in the same cycle db changes and last exactly one cycle.
- Latency from s changing to db changing, input held stable: between (STABLE_TICKS-1)*2^TICK_BITS+1 and STABLE_TICKS*2^TICK_BITS cycles.
- Add 2 cycles for the synchroniser to get latency from sw.

Boundary conditions:
- s mismatch and tick in the same cycle: the tick counts.
- s returning to db in the same cycle as a tick: the return wins; counter cleared, no flip.
- Channels are fully independent; simultaneous flips on several channels all pulse in the same cycle.
- cnt never exceeds STABLE_TICKS; no wrap.
- reset_n asserted mid-wait: the channel returns to LOW with no pulse emitted, either during reset or on release.
- STABLE_TICKS=1: db flips on the first tick after a mismatch is seen.

Test Plan:
Bench parameters: NUM_CH=2, TICK_BITS=2 (tick every 4 cycles), STABLE_TICKS=3.
1. Reset: hold reset_n=0 with sw=2'b11 -> db=rise=fall=0. Release -> tick first pulses at cycle 4, then every 4 cycles.
2. Clean press: sw[0] 0->1 and held -> db[0]=1 within 2+9..2+12 cycles. rise[0] high exactly 1 cycle, coincident with db[0] rising. fall and channel 1 stay 0.
3. Bounce rejection: sw[0] high for 6 cycles, low 1 cycle, repeated 5 times -> db[0] stays 0, no rise pulse.
4. Release: with db[0]=1, sw[0] -> 0 held -> fall[0] single pulse and db[0]=0 after 11..14 cycles. A 1-cycle high glitch during the wait restarts the count.
5. Simultaneous channels: sw=2'b11 in the same cycle -> rise=2'b11 in one cycle. Then only sw[1] drops -> fall=2'b10 and db=2'b01.
6. Reset mid-wait: sw[1]=1, then pull reset_n low after the 2nd tick -> db[1]=0 immediately, no rise pulse. After release, a full 3-tick wait is required again.
